// File: rtl/debug_ctrl_pkg.sv
// Shared run-control encodings: CPU FSM states and board key indices.
// Used by debug_step_ctrl, the CPU top and the display mux.
package debug_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    localparam int unsigned KEY_RUN   = 0;
    localparam int unsigned KEY_STEP  = 1;
    localparam int unsigned KEY_BURST = 2;
    localparam int unsigned KEY_PAGE  = 3;
    localparam int unsigned KEY_W     = 4;

endpackage

// File: rtl/cpu_tick_gen.sv
// Clock divider for the CPU enable: tick_c fires on the last count of each
// RUN_DIV-cycle period while enabled; clr restarts the period at zero.
module cpu_tick_gen #(
    parameter int unsigned RUN_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick_c = en && (div_q == DIV_MAX);

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug run-control: HALT / RUN / BURST scheduling of the CPU clock-enable,
// key arbitration and display page cycling. DEBUG_STEP_BREAK_EN adds breakpoint halt.
module debug_step_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DIV = 4,
    parameter int unsigned STEP_N  = 8,
    parameter int unsigned PAGES   = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [KEY_W-1:0]                             key_pulse,
`ifdef DEBUG_STEP_BREAK_EN
    input  logic                                         bp_hit,
    output logic                                         bp_flag,
`endif
    output logic                                         cpu_en,
    output logic                                         running,
    output logic [1:0]                                   state_o,
    output logic [$clog2(STEP_N+1)-1:0]                  steps_left,
    output logic [((PAGES > 1) ? $clog2(PAGES) : 1)-1:0] page
);

    localparam int unsigned SL_W = $clog2(STEP_N + 1);
    localparam int unsigned PG_W = (PAGES > 1) ? $clog2(PAGES) : 1;

    state_e            state_q,   state_d;
    logic              cpu_en_q,  cpu_en_d;
    logic              running_q, running_d;
    logic [SL_W-1:0]   steps_q,   steps_d;
    logic [PG_W-1:0]   page_q,    page_d;
    logic              tick_c;
    logic              stop_c;

    cpu_tick_gen #(
        .RUN_DIV (RUN_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ST_HALT),
        .en     (state_q != ST_HALT),
        .tick_c (tick_c)
    );

`ifdef DEBUG_STEP_BREAK_EN
    logic bp_flag_q, bp_flag_d;
    assign stop_c  = key_pulse[KEY_RUN] || bp_hit;
    assign bp_flag = bp_flag_q;
`else
    assign stop_c  = key_pulse[KEY_RUN];
`endif

    // Mode sequencing; a stop request always beats a coincident tick.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        steps_d  = steps_q;
        page_d   = page_q;
`ifdef DEBUG_STEP_BREAK_EN
        bp_flag_d = bp_flag_q;
`endif
        if (key_pulse[KEY_PAGE]) begin
            page_d = (page_q == PG_W'(PAGES - 1)) ? '0 : page_q + PG_W'(1);
        end

        case (state_q)
            ST_HALT: begin
                steps_d = '0;
                if (key_pulse[KEY_RUN]) begin
                    state_d = ST_RUN;
`ifdef DEBUG_STEP_BREAK_EN
                    bp_flag_d = 1'b0;
`endif
                end else if (key_pulse[KEY_BURST]) begin
                    state_d = ST_BURST;
                    steps_d = SL_W'(STEP_N);
`ifdef DEBUG_STEP_BREAK_EN
                    bp_flag_d = 1'b0;
`endif
                end else if (key_pulse[KEY_STEP]) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_c) begin
                    state_d = ST_HALT;
                end else begin
                    cpu_en_d = tick_c;
                end
            end
            ST_BURST: begin
                if (stop_c) begin
                    state_d = ST_HALT;
                    steps_d = '0;
                end else if (tick_c) begin
                    cpu_en_d = 1'b1;
                    if (steps_q <= SL_W'(1)) begin
                        state_d = ST_HALT;
                        steps_d = '0;
                    end else begin
                        steps_d = steps_q - SL_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
                steps_d = '0;
            end
        endcase

`ifdef DEBUG_STEP_BREAK_EN
        if ((state_q != ST_HALT) && bp_hit) begin
            bp_flag_d = 1'b1;
        end
`endif
        running_d = (state_d != ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HALT;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            steps_q   <= '0;
            page_q    <= '0;
`ifdef DEBUG_STEP_BREAK_EN
            bp_flag_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
            steps_q   <= steps_d;
            page_q    <= page_d;
`ifdef DEBUG_STEP_BREAK_EN
            bp_flag_q <= bp_flag_d;
`endif
        end
    end

    assign cpu_en     = cpu_en_q;
    assign running    = running_q;
    assign state_o    = state_q;
    assign steps_left = steps_q;
    assign page       = page_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed bench for debug_step_ctrl at RUN_DIV=4, STEP_N=8, PAGES=4.
// Breakpoint checks run only when DEBUG_STEP_BREAK_EN is defined.
module tb_debug_step_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_pulse;
    logic       cpu_en;
    logic       running;
    logic [1:0] state_o;
    logic [3:0] steps_left;
    logic [1:0] page;
`ifdef DEBUG_STEP_BREAK_EN
    logic       bp_hit;
    logic       bp_flag;
`endif

    int checks = 0;
    int errors = 0;
    int pulses;
    int exp_steps;

    debug_step_ctrl #(
        .RUN_DIV (4),
        .STEP_N  (8),
        .PAGES   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_pulse  (key_pulse),
`ifdef DEBUG_STEP_BREAK_EN
        .bp_hit     (bp_hit),
        .bp_flag    (bp_flag),
`endif
        .cpu_en     (cpu_en),
        .running    (running),
        .state_o    (state_o),
        .steps_left (steps_left),
        .page       (page)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs then show the effect of the previous cycle's inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_pulse = k;
        cyc();
        key_pulse = 4'b0000;
    endtask

    initial begin
        rst       = 1'b1;
        key_pulse = 4'b0000;
`ifdef DEBUG_STEP_BREAK_EN
        bp_hit    = 1'b0;
`endif
        cyc();
        cyc();
        rst = 1'b0;

        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_state", 32'(state_o), 0);
        check("rst_running", 32'(running), 0);
        check("rst_steps", 32'(steps_left), 0);
        check("rst_page", 32'(page), 0);

        // Idle in HALT
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("idle_state", 32'(state_o), 0);
            check("idle_steps", 32'(steps_left), 0);
            check("idle_page", 32'(page), 0);
            pulses += int'(cpu_en);
        end
        check("idle_pulses", 32'(pulses), 0);

        // Single steps from HALT: one pulse each, state stays HALT
        pulses = 0;
        for (int n = 0; n < 3; n++) begin
            repeat (4) cyc();
            press(4'b0010);
            check("step_en", 32'(cpu_en), 1);
            check("step_state", 32'(state_o), 0);
            pulses += int'(cpu_en);
            cyc();
            check("step_en_after", 32'(cpu_en), 0);
            pulses += int'(cpu_en);
        end
        check("step_pulses", 32'(pulses), 3);

        // RUN: entry at c=1, pulses at c=5,9; halt key in c=12 suppresses the c=13 pulse
        press(4'b0001);
        check("run_state", 32'(state_o), 1);
        check("run_running", 32'(running), 1);
        check("run_en_c1", 32'(cpu_en), 0);
        for (int c = 2; c <= 12; c++) begin
            cyc();
            check("run_en", 32'(cpu_en), ((c == 5) || (c == 9)) ? 1 : 0);
        end
        press(4'b0001);
        check("run_halt_en", 32'(cpu_en), 0);
        check("run_halt_state", 32'(state_o), 0);
        check("run_halt_running", 32'(running), 0);
        cyc();
        check("run_halt_en2", 32'(cpu_en), 0);

        // Full burst: 8 pulses at c=5,9,..,33; HALT together with the 8th
        press(4'b0100);
        check("burst_state", 32'(state_o), 2);
        check("burst_steps_c1", 32'(steps_left), 8);
        pulses = 0;
        for (int c = 2; c <= 36; c++) begin
            cyc();
            exp_steps = (c >= 33) ? 0 : 8 - (c - 1) / 4;
            check("burst_en", 32'(cpu_en), ((c <= 33) && (c % 4 == 1)) ? 1 : 0);
            check("burst_steps", 32'(steps_left), 32'(exp_steps));
            check("burst_st", 32'(state_o), (c >= 33) ? 0 : 2);
            pulses += int'(cpu_en);
        end
        check("burst_pulses", 32'(pulses), 8);

        // Burst aborted by key[0] after the 3rd pulse (c=13)
        press(4'b0100);
        pulses = 0;
        for (int c = 2; c <= 13; c++) begin
            cyc();
            pulses += int'(cpu_en);
        end
        check("abort_steps_pre", 32'(steps_left), 5);
        press(4'b0001);
        check("abort_state", 32'(state_o), 0);
        check("abort_steps", 32'(steps_left), 0);
        for (int c = 0; c < 10; c++) begin
            pulses += int'(cpu_en);
            cyc();
        end
        check("abort_pulses", 32'(pulses), 3);

        // Simultaneous run/step/burst from HALT: run wins, no step pulse
        press(4'b0111);
        check("prio_state", 32'(state_o), 1);
        check("prio_en", 32'(cpu_en), 0);
        check("prio_steps", 32'(steps_left), 0);
        press(4'b0001);
        check("prio_halt", 32'(state_o), 0);

        // Burst beats step when both arrive together
        press(4'b0110);
        check("prio2_state", 32'(state_o), 2);
        check("prio2_en", 32'(cpu_en), 0);
        press(4'b0001);
        check("prio2_halt", 32'(state_o), 0);

        // Page advance wraps modulo 4
        for (int n = 1; n <= 5; n++) begin
            press(4'b1000);
            check("page_seq", 32'(page), 32'(n % 4));
        end
        // Page advance together with a step is independent of arbitration
        press(4'b1010);
        check("page_step_page", 32'(page), 2);
        check("page_step_en", 32'(cpu_en), 1);

        // Reset mid-burst with steps_left=5
        press(4'b0100);
        for (int c = 2; c <= 13; c++) cyc();
        check("mid_steps", 32'(steps_left), 5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mrst_cpu_en", 32'(cpu_en), 0);
        check("mrst_state", 32'(state_o), 0);
        check("mrst_running", 32'(running), 0);
        check("mrst_steps", 32'(steps_left), 0);
        check("mrst_page", 32'(page), 0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            pulses += int'(cpu_en);
        end
        check("mrst_pulses", 32'(pulses), 0);

`ifdef DEBUG_STEP_BREAK_EN
        // Breakpoint in c=4 coincides with the first tick: halt, flag, no pulse
        press(4'b0001);
        cyc();
        cyc();
        cyc();
        bp_hit = 1'b1;
        cyc();
        bp_hit = 1'b0;
        check("bp_state", 32'(state_o), 0);
        check("bp_flag", 32'(bp_flag), 1);
        check("bp_en", 32'(cpu_en), 0);
        bp_hit = 1'b1;
        cyc();
        bp_hit = 1'b0;
        check("bp_halt_ignored", 32'(state_o), 0);
        check("bp_flag_sticky", 32'(bp_flag), 1);
        press(4'b0001);
        check("bp_clr_flag", 32'(bp_flag), 0);
        check("bp_clr_state", 32'(state_o), 1);
        press(4'b0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_step_ctrl.md
Name: debug_step_ctrl

Overview:
Debug run-control scheduler for the multi-cycle CPU on the board. It consumes the one-cycle key pulses from the debounced board buttons and generates the CPU's clock-enable (cpu_en). It sequences three modes: halted, free-running at a divided rate, and fixed-length bursts. It also arbitrates simultaneous button events and cycles the display page for the debug 7-seg/LED view.

Parameters:
RUN_DIV, 4, system clocks per cpu_en pulse in RUN and BURST; >=1; 1 = cpu_en held high continuously
STEP_N, 8, cpu_en pulses issued per burst command; >=1
PAGES, 4, number of display pages; page wraps modulo PAGES

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
key_pulse  in  4  debounced one-cycle pulses: [0] run/halt toggle, [1] single step, [2] burst of STEP_N, [3] page advance
cpu_en  out  1  registered CPU clock-enable, one system cycle per CPU cycle
running  out  1  high while state is RUN or BURST
state_o  out  2  current state encoding: HALT=0, RUN=1, BURST=2
steps_left  out  $clog2(STEP_N+1)  remaining burst pulses; 0 outside BURST
page  out  $clog2(PAGES) (min 1)  current display page

Behaviour:
- All outputs are registered. Key pulse in cycle t takes effect on the edge ending t, so it is visible in cycle t+1.
- Reset (rst high at an edge): state=HALT, cpu_en=0, running=0, steps_left=0, page=0, divider=0. This applies mid-burst or mid-run too; no pending pulse survives reset.
- Divider div: 0..RUN_DIV-1, cleared on entry to RUN/BURST, increments in RUN/BURST. tick = (div==RUN_DIV-1); on tick, div wraps to 0. First cpu_en occurs RUN_DIV cycles after entry.
- HALT:
  - cpu_en=0 unless a step is issued.
  - Priority for simultaneous key[0..2]: key[0] > key[2] > key[1]. Lower-priority pulses in the same cycle are dropped.
  - key[0] -> RUN.
  - key[2] -> BURST, steps_left=STEP_N.
  - key[1] -> stay HALT, cpu_en=1 for exactly the next cycle.
- RUN:
  - cpu_en = registered tick.
  - key[0] -> HALT. If a tick coincides with the halt key, halt wins and no cpu_en is issued.
  - key[1] and key[2] are ignored.
- BURST:
  - On each tick: cpu_en=1, steps_left-=1. When steps_left goes 1->0, go to HALT in the same edge.
  - Exactly STEP_N pulses are issued, spaced RUN_DIV cycles apart.
  - key[0] aborts -> HALT, steps_left=0, no further cpu_en. A coincident tick is suppressed.
  - key[1] and key[2] are ignored.
- page: key[3] -> page=(page==PAGES-1)?0:page+1 in any state, independent of the key[0..2] arbitration.
- With RUN_DIV=1: cpu_en is high every cycle in RUN, and a burst lasts exactly STEP_N cycles.
- steps_left never underflows. It is forced to 0 on any exit from BURST.

Optional Feature:
Macro DEBUG_STEP_BREAK_EN.
- With it: adds input bp_hit (1) and output bp_flag (1).
  - bp_hit sampled high in RUN or BURST -> HALT next edge, steps_left=0, bp_flag=1. bp_hit has priority over tick, so no cpu_en is issued that cycle.
  - bp_flag is sticky and is cleared when key[0] or key[2] starts a new RUN/BURST.
  - bp_hit is ignored in HALT.
- Without it: neither port exists and the mode logic is unchanged.

Decomposition:
- Package debug_ctrl_pkg: state constants ST_HALT/ST_RUN/ST_BURST (2-bit) and key index constants KEY_RUN=0, KEY_STEP=1, KEY_BURST=2, KEY_PAGE=3. The CPU top and display mux share these.
- One sub-module, cpu_tick_gen: the RUN_DIV divider with clear and enable inputs and a tick output.
- The FSM, arbitration and page counter stay in debug_step_ctrl.

Test Plan:
- Reset, then idle 20 cycles -> cpu_en=0, state_o=0, page=0, steps_left=0 throughout.
- HALT, key[1] pulse at cycle 5 -> cpu_en high only in cycle 6, state_o stays 0. Repeat 3 times -> exactly 3 pulses.
- RUN_DIV=4: key[0] at cycle 10 -> RUN from cycle 11; cpu_en at cycles 15, 19, 23. key[0] at cycle 22 -> HALT at 23 with no pulse at 23.
- STEP_N=8, RUN_DIV=4: key[2] -> exactly 8 cpu_en pulses 4 cycles apart, steps_left counts 8->0, HALT after the 8th. Rerun with key[0] after the 3rd pulse -> only 3 pulses, steps_left=0.
- key[0], key[1], key[2] in the same cycle from HALT -> RUN, no step pulse. key[3] x5 with PAGES=4 -> page sequence 1,2,3,0,1.
- rst asserted mid-burst (steps_left=5) -> next cycle all outputs at reset values. With DEBUG_STEP_BREAK_EN, bp_hit in RUN -> HALT, bp_flag=1, no cpu_en; key[0] clears bp_flag.
